// File: rtl/raster_bitmap_collector_if.sv
// Pixel-in / row-out bundle for raster_bitmap_collector.
// master = rasteriser plus row consumer side, slave = the collector.
interface raster_bitmap_collector_if #(
   parameter int COORD_W = 3,
   parameter int CNT_W   = 7
);
   localparam int GRID = 1 << COORD_W;

   logic               tri_busy;
   logic               po;
   logic [COORD_W-1:0] xo;
   logic [COORD_W-1:0] yo;
   logic               row_vld;
   logic               row_rdy;
   logic [COORD_W-1:0] row_idx;
   logic [GRID-1:0]    row_data;
   logic [CNT_W-1:0]   pix_cnt;
   logic               frame_done;
   logic               dup_err;
   logic               drop_err;

   modport master (
      output tri_busy, po, xo, yo, row_rdy,
      input  row_vld, row_idx, row_data, pix_cnt, frame_done, dup_err, drop_err
   );

   modport slave (
      input  tri_busy, po, xo, yo, row_rdy,
      output row_vld, row_idx, row_data, pix_cnt, frame_done, dup_err, drop_err
   );
endinterface

// File: rtl/raster_bitmap_collector.sv
// raster_bitmap_collector: marks rasterised pixels in a GRID x GRID bitmap,
// counts distinct pixels, and streams the bitmap out row by row once the
// triangle ends, then clears itself for the next triangle.
// Optional feature macro: BBOX_TRACK_EN adds bounding-box outputs
// bb_xmin/bb_xmax/bb_ymin/bb_ymax.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | waiting for tri_busy rise; pixels still captured
//  S_COLLECT | triangle in progress; pixels captured until tri_busy falls
//  S_READ    | bitmap rows offered on row_vld/row_rdy, row rd_ptr
//  S_CLEAR   | one cycle wiping bitmap, count and read pointer
module raster_bitmap_collector #(
   parameter int COORD_W = 3,
   parameter int CNT_W   = 7
) (
   input  logic clk,
   input  logic reset_n,
   raster_bitmap_collector_if.slave bus
`ifdef BBOX_TRACK_EN
   ,
   output logic [COORD_W-1:0] bb_xmin,
   output logic [COORD_W-1:0] bb_xmax,
   output logic [COORD_W-1:0] bb_ymin,
   output logic [COORD_W-1:0] bb_ymax
`endif
);
   localparam int GRID = 1 << COORD_W;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_READ, S_CLEAR} state_t;

   state_t                      state;
   logic                        busy_q;
   logic [COORD_W-1:0]          rd_ptr;
   logic                        frame_done;
   logic [GRID-1:0][GRID-1:0]   bitmap;
   logic [CNT_W-1:0]            pix_cnt;
   logic                        dup_err;
   logic                        drop_err;

   logic rise;
   logic fall;
   logic capture_win;
   logic accept;
   logic hit;

   assign rise        = bus.tri_busy & ~busy_q;
   assign fall        = ~bus.tri_busy & busy_q;
   assign capture_win = (state == S_IDLE) || (state == S_COLLECT);
   assign accept      = bus.po & capture_win;
   assign hit         = bitmap[bus.yo][bus.xo];

   // Sequencer: edge detect on tri_busy, state, read pointer, frame_done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         busy_q     <= 1'b0;
         rd_ptr     <= '0;
         frame_done <= 1'b0;
      end else begin
         busy_q     <= bus.tri_busy;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rise) state <= S_COLLECT;
            end
            S_COLLECT: begin
               if (fall) begin
                  state      <= S_READ;
                  frame_done <= 1'b1;
               end
            end
            S_READ: begin
               if (bus.row_rdy) begin
                  rd_ptr <= rd_ptr + COORD_W'(1);
                  if (&rd_ptr) state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               rd_ptr <= '0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bitmap, distinct-pixel count and sticky error flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitmap   <= '0;
         pix_cnt  <= '0;
         dup_err  <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         // Pixels during readout or clear would corrupt the frame being read
         if (bus.po && !capture_win) drop_err <= 1'b1;
         if (state == S_CLEAR) begin
            bitmap  <= '0;
            pix_cnt <= '0;
         end else if (accept) begin
            if (hit) begin
               dup_err <= 1'b1;
            end else begin
               bitmap[bus.yo][bus.xo] <= 1'b1;
               if (pix_cnt != '1) pix_cnt <= pix_cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef BBOX_TRACK_EN
   // Bounding box of accepted pixels; empty box is min=all-ones, max=0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bb_xmin <= '1;
         bb_xmax <= '0;
         bb_ymin <= '1;
         bb_ymax <= '0;
      end else if (state == S_CLEAR) begin
         bb_xmin <= '1;
         bb_xmax <= '0;
         bb_ymin <= '1;
         bb_ymax <= '0;
      end else if (accept) begin
         if (bus.xo < bb_xmin) bb_xmin <= bus.xo;
         if (bus.xo > bb_xmax) bb_xmax <= bus.xo;
         if (bus.yo < bb_ymin) bb_ymin <= bus.yo;
         if (bus.yo > bb_ymax) bb_ymax <= bus.yo;
      end
   end
`endif

   // Row output is taken straight from registers so it drops on async reset
   assign bus.row_vld    = (state == S_READ);
   assign bus.row_idx    = rd_ptr;
   assign bus.row_data   = bitmap[rd_ptr];
   assign bus.pix_cnt    = pix_cnt;
   assign bus.frame_done = frame_done;
   assign bus.dup_err    = dup_err;
   assign bus.drop_err   = drop_err;
endmodule

// File: tb/tb_raster_bitmap_collector.sv
// Randomised self-checking bench for raster_bitmap_collector. Reference model
// is a plain 8x8 bit array plus a count and two sticky flags.
module tb_raster_bitmap_collector;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   raster_bitmap_collector_if #(.COORD_W(3), .CNT_W(7)) bus ();

`ifdef BBOX_TRACK_EN
   logic [2:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
`endif

   raster_bitmap_collector #(.COORD_W(3), .CNT_W(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
`ifdef BBOX_TRACK_EN
      ,
      .bb_xmin (bb_xmin),
      .bb_xmax (bb_xmax),
      .bb_ymin (bb_ymin),
      .bb_ymax (bb_ymax)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit m [8][8];
   int m_cnt;
   bit m_dup;
   bit m_drop;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear_frame();
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++) m[y][x] = 1'b0;
      m_cnt = 0;
   endtask

   function automatic logic [7:0] exp_row(input int r);
      logic [7:0] v;
      for (int x = 0; x < 8; x++) v[x] = m[r][x];
      return v;
   endfunction

   task automatic do_reset();
      reset_n      = 1'b0;
      bus.tri_busy = 1'b0;
      bus.po       = 1'b0;
      bus.xo       = '0;
      bus.yo       = '0;
      bus.row_rdy  = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      model_clear_frame();
      m_dup  = 1'b0;
      m_drop = 1'b0;
   endtask

   task automatic start_tri();
      bus.tri_busy = 1'b1;
      step();
   endtask

   // One pixel in IDLE/COLLECT; optionally drop tri_busy in the same cycle
   task automatic pixel(input int x, input int y, input bit with_fall);
      bus.po = 1'b1;
      bus.xo = 3'(x);
      bus.yo = 3'(y);
      if (with_fall) bus.tri_busy = 1'b0;
      step();
      bus.po = 1'b0;
      if (m[y][x]) m_dup = 1'b1;
      else begin
         m[y][x] = 1'b1;
         if (m_cnt < 127) m_cnt++;
      end
   endtask

   task automatic read_frame(input int stall_row, input int stall_len, input int drop_row);
      bit seen;
      logic [7:0] exp;
      int st;
      bus.tri_busy = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         if (bus.row_vld === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL row_vld_timeout got=%b exp=1", bus.row_vld);
         return;
      end
      checks++;
      if (bus.frame_done !== 1'b1) begin
         errors++;
         $display("FAIL frame_done_pulse got=%b exp=1", bus.frame_done);
      end
      checks++;
      if (bus.pix_cnt !== 7'(m_cnt)) begin
         errors++;
         $display("FAIL pix_cnt_frame got=%0d exp=%0d", bus.pix_cnt, m_cnt);
      end
      for (int r = 0; r < 8; r++) begin
         exp = exp_row(r);
         st  = (r == stall_row) ? stall_len : int'($urandom_range(2, 0));
         if (r == drop_row && st == 0) st = 1;
         bus.row_rdy = 1'b0;
         for (int s = 0; s < st; s++) begin
            checks++;
            if (bus.row_vld !== 1'b1 || bus.row_idx !== 3'(r) || bus.row_data !== exp) begin
               errors++;
               $display("FAIL row_stall r=%0d got vld=%b idx=%0d data=%h exp vld=1 idx=%0d data=%h",
                        r, bus.row_vld, bus.row_idx, bus.row_data, r, exp);
            end
            if (r == drop_row && s == 0) begin
               bus.po = 1'b1;
               bus.xo = 3'($urandom_range(7, 0));
               bus.yo = 3'($urandom_range(7, 0));
               step();
               bus.po = 1'b0;
               m_drop = 1'b1;
            end else begin
               step();
            end
         end
         bus.row_rdy = 1'b1;
         checks++;
         if (bus.row_vld !== 1'b1 || bus.row_idx !== 3'(r) || bus.row_data !== exp) begin
            errors++;
            $display("FAIL row_accept r=%0d got vld=%b idx=%0d data=%h exp vld=1 idx=%0d data=%h",
                     r, bus.row_vld, bus.row_idx, bus.row_data, r, exp);
         end
         step();
      end
      bus.row_rdy = 1'b0;
      checks++;
      if (bus.row_vld !== 1'b0 || bus.frame_done !== 1'b0) begin
         errors++;
         $display("FAIL clear_cycle got vld=%b fd=%b exp vld=0 fd=0", bus.row_vld, bus.frame_done);
      end
      step();
      model_clear_frame();
      checks++;
      if (bus.pix_cnt !== 7'(m_cnt) || bus.row_vld !== 1'b0 || bus.row_data !== 8'h00) begin
         errors++;
         $display("FAIL after_clear got cnt=%0d vld=%b data=%h exp cnt=0 vld=0 data=00",
                  bus.pix_cnt, bus.row_vld, bus.row_data);
      end
      checks++;
      if (bus.dup_err !== m_dup || bus.drop_err !== m_drop) begin
         errors++;
         $display("FAIL sticky_flags got dup=%b drop=%b exp dup=%b drop=%b",
                  bus.dup_err, bus.drop_err, m_dup, m_drop);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.row_vld !== 1'b0 || bus.pix_cnt !== 7'd0 || bus.dup_err !== 1'b0 ||
          bus.drop_err !== 1'b0 || bus.frame_done !== 1'b0 || bus.row_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_state got vld=%b cnt=%0d dup=%b drop=%b fd=%b data=%h exp all 0",
                  bus.row_vld, bus.pix_cnt, bus.dup_err, bus.drop_err, bus.frame_done, bus.row_data);
      end
   endtask

   task automatic test_basic();
      start_tri();
      pixel(1, 1, 0);
      pixel(1, 2, 0);
      pixel(2, 2, 0);
      pixel(1, 3, 0);
      checks++;
      if (bus.pix_cnt !== 7'd4) begin
         errors++;
         $display("FAIL basic_cnt got=%0d exp=4", bus.pix_cnt);
      end
      checks++;
      if (exp_row(2) !== 8'h06 || exp_row(3) !== 8'h02) begin
         errors++;
         $display("FAIL basic_model got r2=%h r3=%h exp r2=06 r3=02", exp_row(2), exp_row(3));
      end
      read_frame(-1, 0, -1);
   endtask

   task automatic test_dup();
      start_tri();
      pixel(3, 4, 0);
      pixel(3, 4, 0);
      checks++;
      if (bus.pix_cnt !== 7'd1 || bus.dup_err !== 1'b1) begin
         errors++;
         $display("FAIL dup got cnt=%0d dup=%b exp cnt=1 dup=1", bus.pix_cnt, bus.dup_err);
      end
      read_frame(-1, 0, -1);
   endtask

   task automatic test_stall();
      start_tri();
      for (int i = 0; i < 10; i++)
         pixel(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 0);
      read_frame(2, 5, -1);
   endtask

   task automatic test_drop();
      start_tri();
      for (int i = 0; i < 8; i++)
         pixel(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 0);
      read_frame(-1, 0, 3);
      checks++;
      if (bus.drop_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_flag got=%b exp=1", bus.drop_err);
      end
   endtask

   task automatic test_random_frames();
      int n;
      bit lf;
      for (int f = 0; f < 6; f++) begin
         start_tri();
         n  = int'($urandom_range(20, 1));
         lf = 1'($urandom_range(1, 0));
         for (int i = 0; i < n; i++)
            pixel(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), (i == n - 1) && lf);
         read_frame(int'($urandom_range(7, 0)), int'($urandom_range(4, 0)), -1);
      end
   endtask

   task automatic test_reset_mid_read();
      bit seen;
      start_tri();
      pixel(0, 0, 0);
      pixel(7, 7, 0);
      bus.tri_busy = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         if (bus.row_vld === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midread_timeout got=%b exp=1", bus.row_vld);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.row_vld !== 1'b0 || bus.pix_cnt !== 7'd0 || bus.row_data !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got vld=%b cnt=%0d data=%h exp vld=0 cnt=0 data=00",
                  bus.row_vld, bus.pix_cnt, bus.row_data);
      end
      do_reset();
      start_tri();
      pixel(5, 0, 1);
      read_frame(-1, 0, -1);
   endtask

`ifdef BBOX_TRACK_EN
   task automatic test_bbox();
      start_tri();
      pixel(1, 6, 0);
      pixel(5, 2, 0);
      checks++;
      if (bb_xmin !== 3'd1 || bb_xmax !== 3'd5 || bb_ymin !== 3'd2 || bb_ymax !== 3'd6) begin
         errors++;
         $display("FAIL bbox got %0d %0d %0d %0d exp 1 5 2 6", bb_xmin, bb_xmax, bb_ymin, bb_ymax);
      end
      read_frame(-1, 0, -1);
      checks++;
      if (bb_xmin !== 3'd7 || bb_xmax !== 3'd0 || bb_ymin !== 3'd7 || bb_ymax !== 3'd0) begin
         errors++;
         $display("FAIL bbox_clear got %0d %0d %0d %0d exp 7 0 7 0", bb_xmin, bb_xmax, bb_ymin, bb_ymax);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_dup();
      test_stall();
      test_drop();
      test_random_frames();
      test_reset_mid_read();
`ifdef BBOX_TRACK_EN
      test_bbox();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
